// File: rtl/sdi_rx_timing_frontend.sv
// sdi_rx_timing_frontend
//   Input stage between the SDI deserializer parallel bus and the CSI-2 path.
//   Registers the pixel bus, turns vblank/hblank into fv/lv, emits frame/line
//   strobes, checks the raster against H_ACTIVE x V_ACTIVE and gates video
//   until the PLL is locked and a clean frame boundary has been seen.
//   Optional feature: define SDI_RX_LINE_TRUNC_EN to cut lv_o after H_ACTIVE
//   pixels of a line (h_err_o still reports the true line length).
// Ports
//   pix_clk_i, rst_n_i     : pixel clock, async active-low reset
//   pll_lock_i             : deserializer PLL lock (async, 2-flop synchronised)
//   data_i, vblank_i, hblank_i : raw deserializer bus and active-high blanks
//   data_o, fv_o, lv_o     : registered video, 2-cycle latency from the inputs
//   frame_start_o, frame_end_o, line_start_o : boundary strobes
//   h_err_o, v_err_o       : raster length error pulses
//   video_locked_o         : last full frame matched the configured raster
//   line_cnt_o             : 0-based index of the current/last active line
module sdi_rx_timing_frontend #(
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned V_ACTIVE = 1080,
    parameter int unsigned CNT_W    = 12
) (
    input  logic             pix_clk_i,
    input  logic             rst_n_i,
    input  logic             pll_lock_i,
    input  logic [15:0]      data_i,
    input  logic             vblank_i,
    input  logic             hblank_i,
    output logic [15:0]      data_o,
    output logic             fv_o,
    output logic             lv_o,
    output logic             frame_start_o,
    output logic             frame_end_o,
    output logic             line_start_o,
    output logic             h_err_o,
    output logic             v_err_o,
    output logic             video_locked_o,
    output logic [CNT_W-1:0] line_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] H_CMP   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_CMP   = CNT_W'(V_ACTIVE);

    typedef enum logic [1:0] {WAIT_LOCK, WAIT_VBL, WAIT_FRM, ACTIVE} state_t;

    state_t           state, state_nx;
    logic             lock_s1, lock_s2;
    logic [15:0]      data_r;
    logic             vbl_r, hbl_r, vbl_q;
    logic             raw_lv, raw_lv_nx, raw_start, line_end;
    logic [CNT_W-1:0] pix_cnt, pix_nx;
    logic [CNT_W-1:0] lines, lines_nx;
    logic             frame_bad, bad_nx;
    logic             fv_nx, lv_nx, fs_nx, fe_nx, h_err_nx, v_err_nx, locked_nx;
    logic [15:0]      data_nx;
    logic [CNT_W-1:0] line_cnt_nx;
    logic             vbl_rise, vbl_fall;

    assign vbl_rise = vbl_r & ~vbl_q;
    assign vbl_fall = ~vbl_r & vbl_q;

    // Next-state and next-output logic; raw_lv is the untruncated line valid.
    always_comb begin
        state_nx  = state;
        fv_nx     = 1'b0;
        raw_lv_nx = 1'b0;
        fs_nx     = 1'b0;
        fe_nx     = 1'b0;
        if (!lock_s2) begin
            state_nx = WAIT_LOCK;
        end else begin
            unique case (state)
                WAIT_LOCK: state_nx = WAIT_VBL;
                WAIT_VBL:  if (vbl_r) state_nx = WAIT_FRM;
                WAIT_FRM: begin
                    if (vbl_fall) begin
                        state_nx  = ACTIVE;
                        fv_nx     = 1'b1;
                        fs_nx     = 1'b1;
                        raw_lv_nx = ~hbl_r;
                    end
                end
                ACTIVE: begin
                    // vblank edge takes priority over any hblank activity
                    if (vbl_rise) begin
                        state_nx = WAIT_FRM;
                        fe_nx    = 1'b1;
                    end else begin
                        fv_nx     = 1'b1;
                        raw_lv_nx = ~hbl_r;
                    end
                end
                default: state_nx = WAIT_LOCK;
            endcase
        end

        raw_start = raw_lv_nx & ~raw_lv;
        // A line cut by lock loss is not a completed line.
        line_end  = raw_lv & ~raw_lv_nx & lock_s2;

        pix_nx = pix_cnt;
        if (raw_start)
            pix_nx = CNT_W'(1);
        else if (raw_lv_nx && pix_cnt != CNT_MAX)
            pix_nx = pix_cnt + CNT_W'(1);

        lines_nx = lines;
        if (fs_nx)
            lines_nx = '0;
        else if (line_end && lines != CNT_MAX)
            lines_nx = lines + CNT_W'(1);

        h_err_nx = line_end && (pix_cnt != H_CMP);
        v_err_nx = fe_nx && (lines_nx != V_CMP);
        bad_nx   = fs_nx ? 1'b0 : (frame_bad | h_err_nx);

        locked_nx = video_locked_o;
        if (!lock_s2 || h_err_nx || v_err_nx)
            locked_nx = 1'b0;
        else if (fe_nx && !frame_bad)
            locked_nx = 1'b1;

`ifdef SDI_RX_LINE_TRUNC_EN
        // pix_cnt holds pixels already passed, so this cycle is pixel pix_cnt+1
        lv_nx = raw_lv_nx && (raw_start || pix_cnt < H_CMP);
`else
        lv_nx = raw_lv_nx;
`endif

        data_nx     = lv_nx ? data_r : 16'h0000;
        line_cnt_nx = raw_start ? lines_nx : line_cnt_o;
    end

    // Input register, lock synchroniser, state and output registers.
    always_ff @(posedge pix_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= WAIT_LOCK;
            lock_s1        <= 1'b0;
            lock_s2        <= 1'b0;
            data_r         <= '0;
            vbl_r          <= 1'b0;
            hbl_r          <= 1'b0;
            vbl_q          <= 1'b0;
            raw_lv         <= 1'b0;
            pix_cnt        <= '0;
            lines          <= '0;
            frame_bad      <= 1'b0;
            data_o         <= '0;
            fv_o           <= 1'b0;
            lv_o           <= 1'b0;
            frame_start_o  <= 1'b0;
            frame_end_o    <= 1'b0;
            line_start_o   <= 1'b0;
            h_err_o        <= 1'b0;
            v_err_o        <= 1'b0;
            video_locked_o <= 1'b0;
            line_cnt_o     <= '0;
        end else begin
            state          <= state_nx;
            lock_s1        <= pll_lock_i;
            lock_s2        <= lock_s1;
            data_r         <= data_i;
            vbl_r          <= vblank_i;
            hbl_r          <= hblank_i;
            vbl_q          <= vbl_r;
            raw_lv         <= raw_lv_nx;
            pix_cnt        <= pix_nx;
            lines          <= lines_nx;
            frame_bad      <= bad_nx;
            data_o         <= data_nx;
            fv_o           <= fv_nx;
            lv_o           <= lv_nx;
            frame_start_o  <= fs_nx;
            frame_end_o    <= fe_nx;
            line_start_o   <= raw_start;
            h_err_o        <= h_err_nx;
            v_err_o        <= v_err_nx;
            video_locked_o <= locked_nx;
            line_cnt_o     <= line_cnt_nx;
        end
    end

endmodule

// File: tb/tb_sdi_rx_timing_frontend.sv
// Scoreboard bench for sdi_rx_timing_frontend on a reduced 16x6 raster.
module tb_sdi_rx_timing_frontend;

    localparam int H   = 16;
    localparam int V   = 6;
    localparam int CW  = 8;
    localparam int HB  = 6;
    localparam int VBC = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pll_lock = 1'b0;
    logic [15:0]   data = '0;
    logic          vblank = 1'b1;
    logic          hblank = 1'b1;
    logic [15:0]   data_o;
    logic          fv_o, lv_o, frame_start_o, frame_end_o, line_start_o;
    logic          h_err_o, v_err_o, video_locked_o;
    logic [CW-1:0] line_cnt_o;

    sdi_rx_timing_frontend #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(CW)) dut (
        .pix_clk_i      (clk),
        .rst_n_i        (rst_n),
        .pll_lock_i     (pll_lock),
        .data_i         (data),
        .vblank_i       (vblank),
        .hblank_i       (hblank),
        .data_o         (data_o),
        .fv_o           (fv_o),
        .lv_o           (lv_o),
        .frame_start_o  (frame_start_o),
        .frame_end_o    (frame_end_o),
        .line_start_o   (line_start_o),
        .h_err_o        (h_err_o),
        .v_err_o        (v_err_o),
        .video_locked_o (video_locked_o),
        .line_cnt_o     (line_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] d; int c; } pix_t;
    typedef struct { bit ends; int c; int lines; int herr; bit verr; bit locked; } frm_t;

    pix_t dq[$];
    int   fsq[$];
    frm_t fq[$];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic vb, input logic hb, input logic [15:0] d);
        vblank = vb;
        hblank = hb;
        data   = d;
        @(posedge clk);
        #1;
    endtask

    // One frame: active region then trailing vblank. Expectations are pushed
    // at the cycle the relevant input is driven.
    task automatic send_frame(input int nlines, input int long_line, input bit exp_out,
                              input int drop_line, input int drop_pix, input bit exp_locked);
        bit   dropped = 1'b0;
        pix_t p;
        frm_t f;
        int   npix;
        if (exp_out) fsq.push_back(cyc + 2);
        drive(1'b0, 1'b1, 16'h0);
        for (int i = 1; i < HB; i++) drive(1'b0, 1'b1, 16'h0);
        for (int l = 0; l < nlines; l++) begin
            npix = (l == long_line) ? H + 1 : H;
            for (int x = 0; x < npix; x++) begin
                if (l == drop_line && x == drop_pix) begin
                    pll_lock = 1'b0;
                    f.ends = 1'b0; f.c = cyc + 3; f.lines = 0; f.herr = 0;
                    f.verr = 1'b0; f.locked = 1'b0;
                    if (exp_out) fq.push_back(f);
                end
                if (l == drop_line && x == drop_pix + 4) pll_lock = 1'b1;
`ifdef SDI_RX_LINE_TRUNC_EN
                if (exp_out && !dropped && x < H) begin
`else
                if (exp_out && !dropped) begin
`endif
                    p.d = 16'((l << 8) | x);
                    p.c = cyc + 2;
                    dq.push_back(p);
                end
                if (l == drop_line && x == drop_pix) dropped = 1'b1;
                drive(1'b0, 1'b0, 16'((l << 8) | x));
            end
            for (int i = 0; i < HB; i++) drive(1'b0, 1'b1, 16'hBEEF);
        end
        if (exp_out && !dropped) begin
            f.ends = 1'b1; f.c = cyc + 2; f.lines = nlines;
            f.herr = (long_line >= 0) ? 1 : 0;
            f.verr = (nlines != V); f.locked = exp_locked;
            fq.push_back(f);
        end
        for (int i = 0; i < VBC; i++) drive(1'b1, 1'b1, 16'h1234);
    endtask

    // Output monitor, sampling on the falling edge.
    logic fv_p = 1'b0, lv_p = 1'b0;
    int   ls_cnt = 0, he_cnt = 0;
    pix_t me;
    frm_t mf;
    always @(negedge clk) begin
        if (mon_en) begin
            if (!lv_o) check("data_blank", 32'(data_o), 0);
            if (lv_o) begin
                if (dq.size() == 0) check("lv_unexpected", 1, 0);
                else begin
                    me = dq.pop_front();
                    check("data", 32'(data_o), 32'(me.d));
                    check("latency", cyc, me.c);
                end
            end
            check("ls_align", 32'(line_start_o), 32'(lv_o && !lv_p));
            if (fv_o && !fv_p) check("fs_on_fv_rise", 32'(frame_start_o), 1);
            if (frame_start_o) begin
                if (fsq.size() == 0) check("fs_unexpected", 1, 0);
                else check("fs_cycle", cyc, fsq.pop_front());
                ls_cnt = 0;
                he_cnt = 0;
            end
            if (line_start_o) ls_cnt++;
            if (h_err_o) begin
                he_cnt++;
                check("lock_clr_herr", 32'(video_locked_o), 0);
            end
            if (v_err_o && !frame_end_o) check("verr_align", 1, 0);
            if (frame_end_o && !(fv_p && !fv_o)) check("fe_unexpected", 1, 0);
            if (fv_p && !fv_o) begin
                if (fq.size() == 0) check("fv_fall_unexpected", 1, 0);
                else begin
                    mf = fq.pop_front();
                    check("fe_flag", 32'(frame_end_o), 32'(mf.ends));
                    check("fv_fall_cycle", cyc, mf.c);
                    if (mf.ends) begin
                        check("lines", ls_cnt, mf.lines);
                        check("herr_cnt", he_cnt, mf.herr);
                        check("verr", 32'(v_err_o), 32'(mf.verr));
                        check("line_cnt", 32'(line_cnt_o), mf.lines - 1);
                        check("locked", 32'(video_locked_o), 32'(mf.locked));
                    end else begin
                        check("lv_off_lock", 32'(lv_o), 0);
                        check("locked_lockloss", 32'(video_locked_o), 0);
                    end
                end
            end
            lv_p = lv_o;
            fv_p = fv_o;
        end
    end

    initial begin
        repeat (3) drive(1'b1, 1'b1, 16'hFFFF);
        check("rst_fv", 32'(fv_o), 0);
        check("rst_lv", 32'(lv_o), 0);
        check("rst_data", 32'(data_o), 0);
        check("rst_locked", 32'(video_locked_o), 0);
        check("rst_line_cnt", 32'(line_cnt_o), 0);
        check("rst_strobes", 32'({frame_start_o, frame_end_o, line_start_o, h_err_o, v_err_o}), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (cyc >= 10) pll_lock = 1'b1;
            drive(1'b1, 1'b1, 16'h0);
        end
        repeat (3) send_frame(V, -1, 1'b1, -1, -1, 1'b1);  // clean frames
        send_frame(V, 2, 1'b1, -1, -1, 1'b0);              // one over-long line
        send_frame(V, -1, 1'b1, -1, -1, 1'b1);             // recovery
        send_frame(V - 1, -1, 1'b1, -1, -1, 1'b0);         // short frame
        send_frame(V, -1, 1'b1, -1, -1, 1'b1);             // recovery
        send_frame(V, -1, 1'b1, 3, 5, 1'b0);               // lock lost mid-line, relock mid-frame
        send_frame(V, -1, 1'b1, -1, -1, 1'b1);             // first frame after relock
        repeat (10) drive(1'b1, 1'b1, 16'h0);
        check("dq_empty", dq.size(), 0);
        check("fsq_empty", fsq.size(), 0);
        check("fq_empty", fq.size(), 0);

        // Asynchronous reset in the middle of a line.
        mon_en = 1'b0;
        drive(1'b0, 1'b1, 16'h0);
        repeat (3) drive(1'b0, 1'b1, 16'h0);
        repeat (5) drive(1'b0, 1'b0, 16'h5A5A);
        check("pre_rst_fv", 32'(fv_o), 1);
        check("pre_rst_lv", 32'(lv_o), 1);
        rst_n = 1'b0;
        #1;
        check("arst_fv", 32'(fv_o), 0);
        check("arst_lv", 32'(lv_o), 0);
        check("arst_data", 32'(data_o), 0);
        check("arst_locked", 32'(video_locked_o), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
